// File: rtl/gamma_pkg.sv
// ---------------------------------------------------------------------------
// gamma_pkg
//   Shared types for the lagged-Fibonacci gamma coder.
//   BYTE_W       : width of one stream byte
//   gen_state_e  : generator state (unseeded, loading seed, running)
//   byte_t       : one stream / delay-line byte
// ---------------------------------------------------------------------------
package gamma_pkg;

   localparam int BYTE_W = 8;

   typedef enum logic [1:0] {
      ST_UNSEEDED,
      ST_LOAD,
      ST_RUN
   } gen_state_e;

   typedef logic [BYTE_W-1:0] byte_t;

endpackage

// File: rtl/gamma_lfg_coder_cla8.sv
// ---------------------------------------------------------------------------
// gamma_lfg_coder_cla8
//   8-bit carry-lookahead adder with bit-level ports, no carry-in.
//   Two 4-bit lookahead groups; the upper group takes the lower group carry.
//   Ports:
//     a0..a7  in   addend A, a0 = LSB
//     b0..b7  in   addend B, b0 = LSB
//     q0..q7  out  sum, q0 = LSB
//     q8      out  carry-out
// ---------------------------------------------------------------------------
module gamma_lfg_coder_cla8
   import gamma_pkg::*;
(
   input  logic a0, input logic a1, input logic a2, input logic a3,
   input  logic a4, input logic a5, input logic a6, input logic a7,
   input  logic b0, input logic b1, input logic b2, input logic b3,
   input  logic b4, input logic b5, input logic b6, input logic b7,
   output logic q0, output logic q1, output logic q2, output logic q3,
   output logic q4, output logic q5, output logic q6, output logic q7,
   output logic q8
);

   byte_t       a;
   byte_t       b;
   byte_t       g;
   byte_t       p;
   byte_t       sum;
   logic [8:0]  c;

   assign a = {a7, a6, a5, a4, a3, a2, a1, a0};
   assign b = {b7, b6, b5, b4, b3, b2, b1, b0};
   assign g = a & b;
   assign p = a ^ b;

   // Lower nibble: every carry is expanded directly from generate/propagate,
   // so no carry ripples through more than one gate level.
   assign c[0] = 1'b0;
   assign c[1] = g[0];
   assign c[2] = g[1] | (p[1] & g[0]);
   assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]);
   assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);

   // Upper nibble: same expansion, seeded by the lower group carry c[4].
   assign c[5] = g[4] | (p[4] & c[4]);
   assign c[6] = g[5] | (p[5] & g[4]) | (p[5] & p[4] & c[4]);
   assign c[7] = g[6] | (p[6] & g[5]) | (p[6] & p[5] & g[4]) | (p[6] & p[5] & p[4] & c[4]);
   assign c[8] = g[7] | (p[7] & g[6]) | (p[7] & p[6] & g[5]) | (p[7] & p[6] & p[5] & g[4])
               | (p[7] & p[6] & p[5] & p[4] & c[4]);

   assign sum = p ^ c[7:0];

   assign {q7, q6, q5, q4, q3, q2, q1, q0} = sum;
   assign q8 = c[8];

endmodule

// File: rtl/gamma_lfg_coder.sv
// ---------------------------------------------------------------------------
// gamma_lfg_coder
//   Additive lagged-Fibonacci keystream coder:
//     gamma(n) = s(n-LAG_SHORT) + s(n-LAG_LONG) mod 256
//   Each accepted data byte is XORed with gamma and the gamma byte is fed back
//   into the delay line. The delay line is seeded byte-serially; a seed with no
//   odd byte is rejected.
//   Ports:
//     clk, rst             clock, asynchronous active-high reset
//     seed_start           restart: drop pending output, begin seed load
//     seed_valid/seed_data seed byte stream (used only while loading)
//     seed_err             last seed rejected (all bytes even)
//     seeded               generator running
//     in_valid/in_ready/in_data     input byte stream
//     out_valid/out_ready/out_data  coded byte stream, 1-cycle latency
//     gamma_cnt            bytes coded since the last successful seed
// ---------------------------------------------------------------------------
module gamma_lfg_coder
   import gamma_pkg::*;
#(
   parameter int LAG_LONG  = 7,
   parameter int LAG_SHORT = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              seed_start,
   input  logic              seed_valid,
   input  logic [BYTE_W-1:0] seed_data,
   output logic              seed_err,
   output logic              seeded,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [BYTE_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [BYTE_W-1:0] out_data,
   output logic [15:0]       gamma_cnt
);

   if (LAG_LONG < 2 || LAG_LONG > 32 || LAG_SHORT < 1 || LAG_SHORT >= LAG_LONG) begin : g_bad_lags
      $error("gamma_lfg_coder: need 2 <= LAG_LONG <= 32 and 1 <= LAG_SHORT < LAG_LONG");
   end

   gen_state_e  state;
   gen_state_e  state_next;
   byte_t       s [LAG_LONG];
   logic [5:0]  seed_cnt;
   logic        odd_flag;
   byte_t       tap_short;
   byte_t       tap_long;
   byte_t       gamma;
   logic        carry_unused;
   logic        seed_take;
   logic        seed_last;
   logic        seed_good;
   logic        accept;

   assign tap_short = s[LAG_SHORT-1];
   assign tap_long  = s[LAG_LONG-1];

   // The modulo-256 sum only needs the low eight bits; the adder carry-out
   // is deliberately thrown away.
   gamma_lfg_coder_cla8 u_adder (
      .a0(tap_short[0]), .a1(tap_short[1]), .a2(tap_short[2]), .a3(tap_short[3]),
      .a4(tap_short[4]), .a5(tap_short[5]), .a6(tap_short[6]), .a7(tap_short[7]),
      .b0(tap_long[0]),  .b1(tap_long[1]),  .b2(tap_long[2]),  .b3(tap_long[3]),
      .b4(tap_long[4]),  .b5(tap_long[5]),  .b6(tap_long[6]),  .b7(tap_long[7]),
      .q0(gamma[0]), .q1(gamma[1]), .q2(gamma[2]), .q3(gamma[3]),
      .q4(gamma[4]), .q5(gamma[5]), .q6(gamma[6]), .q7(gamma[7]),
      .q8(carry_unused)
   );

   // seed_start overrides everything, so a seed byte or data byte presented
   // in the same cycle is never consumed.
   assign seed_take = (state == ST_LOAD) && seed_valid && !seed_start;
   assign seed_last = (seed_cnt == 6'(LAG_LONG - 1));
   assign seed_good = odd_flag | seed_data[0];
   assign accept    = in_valid && in_ready;
   assign seeded    = (state == ST_RUN);

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_UNSEEDED;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and input-ready logic. A new byte is taken only when the
   // output register is empty or being drained this cycle.
   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      if (seed_start) begin
         state_next = ST_LOAD;
      end else begin
         case (state)
            ST_LOAD: begin
               if (seed_take && seed_last) begin
                  state_next = seed_good ? ST_RUN : ST_UNSEEDED;
               end
            end
            ST_RUN: begin
               in_ready = !out_valid || out_ready;
            end
            default: begin
               state_next = ST_UNSEEDED;
            end
         endcase
      end
   end

   // Delay line: advances only on a seed byte or an accepted data byte,
   // never on idle cycles, so the keystream depends on byte count alone.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < LAG_LONG; i++) begin
            s[i] <= '0;
         end
      end else if (seed_take || accept) begin
         for (int i = LAG_LONG - 1; i > 0; i--) begin
            s[i] <= s[i-1];
         end
         s[0] <= seed_take ? seed_data : gamma;
      end
   end

   // Seed byte counter and the running "any odd byte seen" flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         seed_cnt <= '0;
         odd_flag <= 1'b0;
      end else if (seed_start) begin
         seed_cnt <= '0;
         odd_flag <= 1'b0;
      end else if (seed_take) begin
         seed_cnt <= seed_cnt + 6'd1;
         odd_flag <= odd_flag | seed_data[0];
      end
   end

   // Rejection flag: set when a full seed contained only even bytes, held
   // until the next seed attempt begins.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         seed_err <= 1'b0;
      end else if (seed_start) begin
         seed_err <= 1'b0;
      end else if (seed_take && seed_last && !seed_good) begin
         seed_err <= 1'b1;
      end
   end

   // Output register. A restart drops any pending byte; otherwise a new
   // byte replaces the old one, and an unreplaced byte clears once taken.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (seed_start) begin
         out_valid <= 1'b0;
      end else if (accept) begin
         out_valid <= 1'b1;
         out_data  <= in_data ^ gamma;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   // Coded-byte counter, restarted when a seed completes successfully.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gamma_cnt <= '0;
      end else if (seed_take && seed_last && seed_good) begin
         gamma_cnt <= '0;
      end else if (accept) begin
         gamma_cnt <= gamma_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_gamma_lfg_coder.sv
// ---------------------------------------------------------------------------
// tb_gamma_lfg_coder
//   Self-checking bench for gamma_lfg_coder (LAG_LONG = 7, LAG_SHORT = 3).
//   A keystream model built on the plain recurrence over a byte history
//   predicts every output each cycle; directed cases pin literal values.
// ---------------------------------------------------------------------------
module tb_gamma_lfg_coder;

   localparam int LL = 7;
   localparam int LS = 3;

   logic        clk;
   logic        rst;
   logic        seed_start;
   logic        seed_valid;
   logic [7:0]  seed_data;
   logic        seed_err;
   logic        seeded;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_data;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  out_data;
   logic [15:0] gamma_cnt;

   int cmpCount  = 0;
   int failCount = 0;
   bit chkEn     = 0;

   gamma_lfg_coder #(.LAG_LONG(LL), .LAG_SHORT(LS)) dut (
      .clk(clk), .rst(rst),
      .seed_start(seed_start), .seed_valid(seed_valid), .seed_data(seed_data),
      .seed_err(seed_err), .seeded(seeded),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .gamma_cnt(gamma_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: seq holds the byte history s(0), s(1), ... (oldest first);
   // each new keystream byte is seq[n-LS] + seq[n-LL] mod 256.
   logic [7:0]  seq [$];
   bit          mRun = 0;
   bit          mLoad = 0;
   bit          mErr = 0;
   bit          mOv = 0;
   logic [7:0]  mOd = 0;
   logic [15:0] mCnt = 0;
   int          mSeedCnt = 0;
   bit          lastAcc = 0;
   logic [7:0]  lastCipher = 0;
   int          n;
   int          sum;
   logic [7:0]  g;
   bit          anyOdd;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mRun = 0; mLoad = 0; mErr = 0; mOv = 0; mOd = 0; mCnt = 0;
         mSeedCnt = 0; lastAcc = 0;
         seq.delete();
      end else begin
         lastAcc = mRun && in_valid && (!mOv || out_ready) && !seed_start;
         if (seed_start) begin
            mLoad = 1; mRun = 0; mErr = 0; mOv = 0; mSeedCnt = 0;
            seq.delete();
         end else if (mLoad && seed_valid) begin
            seq.push_back(seed_data);
            mSeedCnt++;
            if (mSeedCnt == LL) begin
               anyOdd = 0;
               foreach (seq[k]) if (seq[k] % 2 == 1) anyOdd = 1;
               mLoad = 0;
               if (anyOdd) begin
                  mRun = 1;
                  mCnt = 0;
               end else begin
                  mErr = 1;
               end
            end
         end else if (lastAcc) begin
            n   = seq.size();
            sum = int'(seq[n-LS]) + int'(seq[n-LL]);
            g   = 8'(sum % 256);
            seq.push_back(g);
            if (seq.size() > 64) void'(seq.pop_front());
            mOd = in_data ^ g;
            lastCipher = mOd;
            mOv = 1;
            mCnt = mCnt + 16'd1;
         end else if (out_ready) begin
            mOv = 0;
         end
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      cmpCount++;
      if (act !== exp) begin
         failCount++;
         $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
      end
   endtask

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (chkEn) begin
         checkOutput("cmp_seeded",    {31'd0, seeded},    {31'd0, mRun});
         checkOutput("cmp_seed_err",  {31'd0, seed_err},  {31'd0, mErr});
         checkOutput("cmp_out_valid", {31'd0, out_valid}, {31'd0, mOv});
         checkOutput("cmp_out_data",  {24'd0, out_data},  {24'd0, mOd});
         checkOutput("cmp_gamma_cnt", {16'd0, gamma_cnt}, {16'd0, mCnt});
         checkOutput("cmp_in_ready",  {31'd0, in_ready},
                     {31'd0, mRun && (!mOv || out_ready) && !seed_start});
      end
   end

   task automatic applyStimulus(input bit ss, input bit sv, input logic [7:0] sd,
                                input bit iv, input logic [7:0] id, input bit orr);
      seed_start = ss; seed_valid = sv; seed_data = sd;
      in_valid = iv; in_data = id; out_ready = orr;
      @(posedge clk);
      #1;
   endtask

   task automatic seedWith(input logic [7:0] b [LL], input bit withStart);
      if (withStart) applyStimulus(1, 0, 8'h00, 0, 8'h00, 1);
      for (int i = 0; i < LL; i++) applyStimulus(0, 1, b[i], 0, 8'h00, 1);
   endtask

   task automatic doReset();
      seed_start = 0; seed_valid = 0; seed_data = 0;
      in_valid = 0; in_data = 0; out_ready = 0;
      rst = 1;
      #2;
      checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
      checkOutput("rst_out_data",  {24'd0, out_data},  32'd0);
      checkOutput("rst_gamma_cnt", {16'd0, gamma_cnt}, 32'd0);
      checkOutput("rst_seeded",    {31'd0, seeded},    32'd0);
      checkOutput("rst_seed_err",  {31'd0, seed_err},  32'd0);
      checkOutput("rst_in_ready",  {31'd0, in_ready},  32'd0);
      @(posedge clk);
      #1;
      rst = 0;
   endtask

   logic [7:0] ramp [LL] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
   logic [7:0] allFF [LL] = '{default: 8'hFF};
   logic [7:0] all02 [LL] = '{default: 8'h02};
   logic [7:0] key [LL];
   logic [7:0] plain [16];
   logic [7:0] cipher [16];

   task automatic runTest1();
      seedWith(ramp, 1);
      checkOutput("t1_seeded", {31'd0, seeded}, 32'd1);
      applyStimulus(0, 0, 8'h00, 1, 8'h00, 1);
      checkOutput("t1_valid0", {31'd0, out_valid}, 32'd1);
      checkOutput("t1_out0", {24'd0, out_data}, 32'h06);
      applyStimulus(0, 0, 8'h00, 1, 8'h00, 1);
      checkOutput("t1_out1", {24'd0, out_data}, 32'h08);
      applyStimulus(0, 0, 8'h00, 1, 8'h00, 1);
      checkOutput("t1_out2", {24'd0, out_data}, 32'h0A);
      checkOutput("t1_cnt", {16'd0, gamma_cnt}, 32'd3);
      applyStimulus(0, 0, 8'h00, 0, 8'h00, 1);
      checkOutput("t1_drain", {31'd0, out_valid}, 32'd0);
   endtask

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int k;
      bit iv, orr;

      rst = 1;
      seed_start = 0; seed_valid = 0; seed_data = 0;
      in_valid = 0; in_data = 0; out_ready = 0;
      @(posedge clk);
      #1;
      rst = 0;
      chkEn = 1;
      doReset();

      $display("[TB] test 1: ramp seed");
      runTest1();

      $display("[TB] test 2: carry dropped");
      seedWith(allFF, 1);
      applyStimulus(0, 0, 8'h00, 1, 8'hFF, 1);
      checkOutput("t2_out", {24'd0, out_data}, 32'h01);

      $display("[TB] test 3: all-even seed rejected");
      seedWith(all02, 1);
      checkOutput("t3_err", {31'd0, seed_err}, 32'd1);
      checkOutput("t3_seeded", {31'd0, seeded}, 32'd0);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(0, 0, 8'h00, 1, 8'h33, 1);
         checkOutput("t3_in_ready", {31'd0, in_ready}, 32'd0);
      end

      $display("[TB] test 4: backpressure");
      seedWith(ramp, 1);
      applyStimulus(0, 0, 8'h00, 1, 8'h00, 1);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(0, 0, 8'h00, 1, 8'h00, 0);
         checkOutput("t4_hold", {24'd0, out_data}, 32'h06);
         checkOutput("t4_in_ready", {31'd0, in_ready}, 32'd0);
         checkOutput("t4_cnt", {16'd0, gamma_cnt}, 32'd1);
      end
      applyStimulus(0, 0, 8'h00, 1, 8'h00, 1);
      checkOutput("t4_out1", {24'd0, out_data}, 32'h08);
      applyStimulus(0, 0, 8'h00, 1, 8'h00, 1);
      checkOutput("t4_out2", {24'd0, out_data}, 32'h0A);

      $display("[TB] test 5: seed_start beats input");
      seedWith(ramp, 1);
      applyStimulus(0, 0, 8'h00, 1, 8'h00, 1);
      applyStimulus(1, 0, 8'h00, 1, 8'h55, 1);
      checkOutput("t5_valid", {31'd0, out_valid}, 32'd0);
      checkOutput("t5_cnt", {16'd0, gamma_cnt}, 32'd1);
      seedWith(ramp, 0);
      applyStimulus(0, 0, 8'h00, 1, 8'h00, 1);
      checkOutput("t5_out", {24'd0, out_data}, 32'h06);

      $display("[TB] test 6: reset mid-load");
      applyStimulus(1, 0, 8'h00, 0, 8'h00, 1);
      for (int i = 0; i < 4; i++) applyStimulus(0, 1, ramp[i], 0, 8'h00, 1);
      doReset();
      runTest1();

      $display("[TB] test 7: random round trip");
      for (int i = 0; i < LL; i++) key[i] = 8'($urandom);
      key[0][0] = 1'b1;
      for (int i = 0; i < 16; i++) plain[i] = 8'($urandom);
      seedWith(key, 1);
      k = 0;
      for (int c = 0; c < 2000 && k < 16; c++) begin
         iv = ($urandom_range(0, 3) != 0);
         orr = ($urandom_range(0, 2) != 0);
         applyStimulus(0, 0, 8'h00, iv, plain[k], orr);
         if (lastAcc) begin
            cipher[k] = lastCipher;
            k++;
         end
      end
      checkOutput("rt_encode_done", k, 16);
      seedWith(key, 1);
      k = 0;
      for (int c = 0; c < 2000 && k < 16; c++) begin
         iv = ($urandom_range(0, 3) != 0);
         orr = ($urandom_range(0, 2) != 0);
         applyStimulus(0, 0, 8'h00, iv, cipher[k], orr);
         if (lastAcc) begin
            checkOutput("rt_plain", {24'd0, out_data}, {24'd0, plain[k]});
            k++;
         end
      end
      checkOutput("rt_decode_done", k, 16);

      $display("[TB] random stress");
      seedWith(key, 1);
      for (int c = 0; c < 400; c++) begin
         applyStimulus($urandom_range(0, 49) == 0, $urandom_range(0, 1) == 1, 8'($urandom),
                       $urandom_range(0, 1) == 1, 8'($urandom), $urandom_range(0, 1) == 1);
      end

      $display("[TB] gamma_cnt wrap");
      seedWith(ramp, 1);
      for (int i = 0; i < 65536; i++) begin
         applyStimulus(0, 0, 8'h00, 1, 8'($urandom), 1);
         if (i == 65534) checkOutput("wrap_ffff", {16'd0, gamma_cnt}, 32'hFFFF);
      end
      checkOutput("wrap_zero", {16'd0, gamma_cnt}, 32'd0);

      applyStimulus(0, 0, 8'h00, 0, 8'h00, 1);
      chkEn = 0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, failCount);
      $finish;
   end

endmodule
